// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared definitions for the VGA raster timing generator.
//   - DEF_* : 640x480 @ 60 Hz default geometry and pipeline delay
//   - H_TOTAL/V_TOTAL and sync window bounds derived from the defaults
//   - coord_t : raster coordinate type used on DrawX/DrawY
//   - in_range() : half-open window test used by the sync/blank decoders
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_PIPE_DELAY = 1;

    localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC;
    localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC;

    // Compared as int so a bound of 1024 (one past the largest coord_t) works.
    function automatic logic in_range(input coord_t v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if
// Raster timing bundle from the generator to the renderers / connector.
//   DrawX, DrawY      : current column / line
//   blank             : 1 = active video
//   hs, vs            : raw active-low syncs aligned with DrawX/DrawY
//   hs_d, vs_d        : syncs delayed to match the renderer pipeline
//   frame_start       : one-tick pulse at (0,0)
//   line_start        : one-tick pulse at DrawX = 0
// master = generator side, slave = consumer side.
interface vga_timing_if;
    import vga_timing_pkg::*;

    coord_t DrawX;
    coord_t DrawY;
    logic   blank;
    logic   hs;
    logic   vs;
    logic   hs_d;
    logic   vs_d;
    logic   frame_start;
    logic   line_start;

    modport master (
        output DrawX, DrawY, blank, hs, vs, hs_d, vs_d, frame_start, line_start
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs, hs_d, vs_d, frame_start, line_start
    );
endinterface

// File: rtl/vga_sync_delay.sv
// vga_sync_delay
// DEPTH-stage shift register for the hs/vs pair, advancing only on ce.
// All stages load 1 (sync inactive) on reset so the connector never sees a
// spurious sync pulse while the pipeline refills.
//   clk, rst_n    : clock, synchronous active-low reset
//   ce            : pixel tick enable
//   hs_in, vs_in  : raw syncs
//   hs_out, vs_out: syncs delayed by DEPTH ticks (DEPTH >= 1)
module vga_sync_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic hs_in,
    input  logic vs_in,
    output logic hs_out,
    output logic vs_out
);

    logic [DEPTH-1:0] hs_sr_q, hs_sr_d;
    logic [DEPTH-1:0] vs_sr_q, vs_sr_d;

    // Bit 0 takes the newest sample; the oldest falls off the top.
    always_comb begin
        hs_sr_d = hs_sr_q;
        vs_sr_d = vs_sr_q;
        if (ce) begin
            hs_sr_d = DEPTH'({hs_sr_q, hs_in});
            vs_sr_d = DEPTH'({vs_sr_q, vs_in});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_sr_q <= '1;
            vs_sr_q <= '1;
        end else begin
            hs_sr_q <= hs_sr_d;
            vs_sr_q <= vs_sr_d;
        end
    end

    assign hs_out = hs_sr_q[DEPTH-1];
    assign vs_out = vs_sr_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// VGA raster timing generator (default 640x480 @ 60 Hz, 800x525 total).
//   vga_clk  : single clock, rising edge
//   reset_n  : synchronous active-low reset
//   pix_ce   : pixel tick enable (tie to 1 when vga_clk is the pixel clock)
//   vga      : vga_timing_if.master carrying DrawX/DrawY, blank, hs/vs,
//              delayed hs_d/vs_d, frame_start and line_start
// Every output is a flop loaded from the *next* counter values, so the
// coordinates and all flags change together on the same tick.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic         vga_clk,
    input  logic         reset_n,
    input  logic         pix_ce,
    vga_timing_if.master vga
);

    localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO = H_ACTIVE + H_FP;
    localparam int HS_HI = HS_LO + H_SYNC;
    localparam int VS_LO = V_ACTIVE + V_FP;
    localparam int VS_HI = VS_LO + V_SYNC;

    localparam coord_t H_LAST = coord_t'(HT - 1);
    localparam coord_t V_LAST = coord_t'(VT - 1);

    if (HT > 1024 || VT > 1024 || PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_cfg
        $error("vga_timing_gen: totals must be <= 1024 and PIPE_DELAY within 0..7");
    end

    coord_t hc_q, hc_d, vc_q, vc_d;
    coord_t hc_nxt, vc_nxt;
    logic   hc_wrap;
    logic   blank_q, blank_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   frame_start_q, frame_start_d;
    logic   line_start_q, line_start_d;
    logic   hs_dly, vs_dly;

    always_comb begin
        hc_wrap = (hc_q == H_LAST);
        hc_nxt  = hc_wrap ? '0 : hc_q + coord_t'(1);
        vc_nxt  = vc_q;
        if (hc_wrap) begin
            vc_nxt = (vc_q == V_LAST) ? '0 : vc_q + coord_t'(1);
        end

        // Hold everything between pixel ticks; pulses therefore stretch
        // across idle cycles but last exactly one tick.
        hc_d          = hc_q;
        vc_d          = vc_q;
        blank_d       = blank_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = frame_start_q;
        line_start_d  = line_start_q;

        if (pix_ce) begin
            hc_d          = hc_nxt;
            vc_d          = vc_nxt;
            blank_d       = in_range(hc_nxt, 0, H_ACTIVE) && in_range(vc_nxt, 0, V_ACTIVE);
            hsync_d       = !in_range(hc_nxt, HS_LO, HS_HI);
            vsync_d       = !in_range(vc_nxt, VS_LO, VS_HI);
            line_start_d  = (hc_nxt == '0);
            frame_start_d = (hc_nxt == '0) && (vc_nxt == '0);
        end
    end

    // Reset wins over pix_ce so a mid-frame reset lands on the very next edge.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hc_q          <= '0;
            vc_q          <= '0;
            blank_q       <= 1'b1;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            blank_q       <= blank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    // A zero-depth delay is a plain wire so the raw syncs reach the connector.
    if (PIPE_DELAY == 0) begin : g_no_delay
        assign hs_dly = hsync_q;
        assign vs_dly = vsync_q;
    end else begin : g_delay
        vga_sync_delay #(
            .DEPTH (PIPE_DELAY)
        ) u_sync_delay (
            .clk    (vga_clk),
            .rst_n  (reset_n),
            .ce     (pix_ce),
            .hs_in  (hsync_q),
            .vs_in  (vsync_q),
            .hs_out (hs_dly),
            .vs_out (vs_dly)
        );
    end

    assign vga.DrawX       = hc_q;
    assign vga.DrawY       = vc_q;
    assign vga.blank       = blank_q;
    assign vga.hs          = hsync_q;
    assign vga.vs          = vsync_q;
    assign vga.hs_d        = hs_dly;
    assign vga.vs_d        = vs_dly;
    assign vga.frame_start = frame_start_q;
    assign vga.line_start  = line_start_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing: pixel coordinates `DrawX`/`DrawY`, the active-video flag `blank`, and active-low `hs`/`vs` syncs. It sits directly upstream of the sprite/background renderers, which consume `DrawX`, `DrawY` and `blank` and return registered RGB. The sync outputs are delayed to line up with that RGB at the monitor connector. Runs on the 25 MHz pixel clock, or on a faster clock qualified by `pix_ce`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync pulse width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vsync width in lines
- `V_BP`, 33, vertical back porch
- `PIPE_DELAY`, 1, downstream pixel-pipeline latency in pixel ticks (0–7)

- `vga_clk`  in  1  single clock; all logic is on its rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `pix_ce`  in  1  pixel tick enable; tie to 1 when `vga_clk` is the pixel clock
- `DrawX`  out  10  current column, 0..H_TOTAL-1
- `DrawY`  out  10  current line, 0..V_TOTAL-1
- `blank`  out  1  1 = active video (DrawX < H_ACTIVE and DrawY < V_ACTIVE)
- `hs`  out  1  raw hsync, active low, aligned with DrawX
- `vs`  out  1  raw vsync, active low, aligned with DrawY
- `hs_d`  out  1  `hs` delayed PIPE_DELAY ticks, for the connector
- `vs_d`  out  1  `vs` delayed PIPE_DELAY ticks, for the connector
- `frame_start`  out  1  one-tick pulse while DrawX=0, DrawY=0
- `line_start`  out  1  one-tick pulse while DrawX=0

## Operation
- Derived constants: H_TOTAL = sum of the H params = 800; V_TOTAL = sum of the V params = 525.
- Horizontal counter `hc`:
  - increments on each `pix_ce`;
  - wraps from H_TOTAL-1 to 0.
- Vertical counter `vc`:
  - increments only on a `pix_ce` where `hc` wraps;
  - wraps from V_TOTAL-1 to 0.
  - `hc` and `vc` wrap together from (799,524) to (0,0) on one tick.
- All outputs are registered and are mutually consistent in the same cycle. Flags are decoded from the next counter values, not from the current ones.
- `hs` = 0 iff H_ACTIVE+H_FP ≤ DrawX < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- `vs` = 0 iff V_ACTIVE+V_FP ≤ DrawY < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- `blank` = 1 iff DrawX < 640 and DrawY < 480.
- `hs_d`/`vs_d`:
  - produced by a PIPE_DELAY-deep shift register that advances only on `pix_ce`;
  - the register is filled with 1s at reset;
  - PIPE_DELAY = 0 makes them combinational copies of `hs`/`vs`.
- When `pix_ce` = 0, every output holds its value.
- Elaboration error if H_TOTAL > 1024, V_TOTAL > 1024, or PIPE_DELAY > 7.

## Timing
- Reset values, while `reset_n` is sampled 0:
  - DrawX = 0, DrawY = 0, blank = 1;
  - hs = hs_d = vs = vs_d = 1;
  - frame_start = 0, line_start = 0.
- Reset mid-frame takes effect on the next edge, regardless of `pix_ce`. There is no partial-line recovery.
- First `pix_ce` tick after reset release gives DrawX = 1.
- First `frame_start` arrives exactly H_TOTAL*V_TOTAL = 420000 ticks after release. The first `line_start` arrives 800 ticks after release.
- Line period: 800 ticks. Frame period: 420000 ticks. hs low for 96 ticks per line. vs low for 1600 ticks per frame.
- Downstream renderers register RGB one tick after DrawX, so `hs_d`/`vs_d` with PIPE_DELAY = 1 align with that RGB.
- `frame_start` and `line_start` are high for exactly one `pix_ce` tick. They stay high across any intervening `pix_ce` = 0 cycles.

## Structure
- Package `vga_timing_pkg`:
  - the 640x480 default constants;
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - a `coord_t` = logic [9:0] typedef.
- One sub-module, `vga_sync_delay`: a parameterised shift register for the hs/vs pair, with enable and reset-to-1.

## Test plan
- **Reset then free-run** (`pix_ce` = 1): after reset release, DrawX reaches 799 at tick 799 and returns to 0 at tick 800 with DrawY = 1.
- **hsync width and position:** over one line, `hs` is low exactly for DrawX 656..751 (96 ticks). `blank` falls after DrawX = 639 and rises again at DrawX = 0.
- **Frame boundary:** at (799,524) the next tick is (0,0) with `frame_start` = 1. `vs` is low only on lines 490–491, 1600 ticks in total.
- **pix_ce = 1 every other cycle:** all outputs hold on the off cycles. Frame period measures 840000 `vga_clk` cycles.
- **Delay alignment:** with PIPE_DELAY = 1, `hs_d` falls exactly 1 tick after `hs`. With PIPE_DELAY = 0, `hs_d` equals `hs`.
- **Reset asserted mid-frame at (300,200):** the next edge gives DrawX = 0, DrawY = 0, hs_d = vs_d = 1, frame_start = 0.
